lfm_chirp_sequencer: RTL
========================

# lfm_chirp_sequencer

Profile-table sequencer in front of `dds_lfm`. It stores up to 2^PROF_BITS chirp profiles (start/stop frequency, length, inter-chirp gap) and plays profiles 0..`seq_last` back-to-back. Each chirp is fired with a one-cycle `dds_start` pulse; the sequencer waits for `dds_done`, then inserts the gap. Playback runs for `loops` passes, or continuously when `loops` = 0, and supports abort and a start-handshake watchdog.

## Interface
Parameters:
- PROF_BITS, 2, profile index width (4 profiles)
- F_CLK, 100_000_000, value driven on `dds_f_clk`
- BUSY_TMO, 8, cycles allowed between `dds_start` and `dds_busy` rising

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- cfg_we  in  1  write profile `cfg_addr`
- cfg_addr  in  PROF_BITS  profile index
- cfg_f_start  in  32  start frequency, Hz
- cfg_f_stop  in  32  stop frequency, Hz
- cfg_chirp_len  in  64  chirp length, samples
- cfg_gap  in  32  idle cycles after the chirp
- cfg_err  out  1  one-cycle pulse: write rejected (not IDLE)
- seq_last  in  PROF_BITS  last profile of a pass
- loops  in  16  passes to play; 0 = continuous
- run  in  1  start playback (sampled in IDLE only)
- abort  in  1  stop playback immediately
- dds_rst_n  out  1  reset to `dds_lfm`, active-low
- dds_start  out  1  one-cycle start pulse
- dds_f_start / dds_f_stop  out  32  registered profile frequencies
- dds_chirp_len  out  64  registered profile length
- dds_f_clk  out  32  constant F_CLK
- dds_busy  in  1  from `dds_lfm`
- dds_done  in  1  from `dds_lfm`
- seq_busy  out  1  high in every state except IDLE
- seq_done  out  1  one-cycle pulse on normal completion
- cur_prof  out  PROF_BITS  profile being played
- pass_cnt  out  16  completed passes, wraps at 2^16
- err  out  1  sticky watchdog error, cleared by `run` or `rst`

## Operation
- States: IDLE, LOAD, START, WAIT_BUSY, WAIT_DONE, GAP, NEXT.
- **IDLE:** `cfg_we` writes the table. On `run`: `cur_prof` ← 0, `pass_cnt` ← 0, `err` ← 0, go to LOAD.
- **LOAD:** table[`cur_prof`] is latched into the `dds_*` registers and the gap counter.
- **START:** `dds_start` = 1, go to WAIT_BUSY.
- **WAIT_BUSY:**
  - `dds_busy` high → WAIT_DONE.
  - After BUSY_TMO cycles without `dds_busy` → `err` ← 1, IDLE, no `seq_done`.
- **WAIT_DONE:** `dds_done` (or `dds_busy` falling) → GAP.
- **GAP:** count down `cfg_gap` cycles. Gap = 0 goes straight to NEXT.
- **NEXT:**
  - `cur_prof` ≠ `seq_last` → `cur_prof`+1, LOAD.
  - Otherwise `pass_cnt`+1. If `loops` ≠ 0 and the new `pass_cnt` = `loops` → pulse `seq_done`, IDLE. Else `cur_prof` ← 0, LOAD.
- `cfg_we` outside IDLE: table unchanged, `cfg_err` pulse.
- `seq_last`, `loops` and F_CLK are sampled continuously; software must hold them stable during playback.
- **abort** (any non-IDLE state; highest priority over all transitions): `dds_rst_n` low for exactly 1 cycle, return to IDLE, no `seq_done`, `err` unchanged. `abort` in IDLE has no effect.
- `run` outside IDLE is ignored.

## Timing
- Reset values: state IDLE, all `dds_*` data outputs 0, `dds_start` 0, `dds_rst_n` 0 during `rst` then 1, `seq_busy`/`seq_done`/`cfg_err`/`err` 0, `cur_prof` 0, `pass_cnt` 0, table contents 0.
- `run` sampled at edge t → `dds_start` high in cycle t+2, with `dds_*` data already valid from t+2.
- `dds_done` sampled at edge d, gap G:
  - G > 0: next `dds_start` at d+G+4.
  - G = 0: next `dds_start` at d+3.
- All outputs are registered. `cfg_err` appears 1 cycle after the write.
- `rst` mid-playback: everything returns to reset values next cycle and the table is cleared.

## Structure
- Shared package `lfm_pkg`: profile struct {f_start 32, f_stop 32, chirp_len 64, gap 32}, state enum, width constants (FREQ_W=32, LEN_W=64).
- One sub-module, `lfm_profile_ram`: 1 write / 1 async-read register file, depth 2^PROF_BITS.
- `dds_lfm` is instantiated by the parent, not inside this block.

## Test plan
- Single profile: {f_start 10, f_stop 1000, chirp_len 100, gap 0}, `seq_last`=0, `loops`=1; use the real `dds_lfm` → one `dds_start` at t+2, `seq_done` 1 pulse, `pass_cnt`=1.
- Three profiles, gaps {5,0,20}, `loops`=2 → 6 `dds_start` pulses in order 0,1,2,0,1,2; start-to-start spacing matches the d+G+4 / d+3 rule; `pass_cnt`=2.
- `loops`=0 → after 10 chirps `seq_done` never asserted; `pass_cnt` keeps counting.
- Stub DDS that never raises `dds_busy` → `err`=1 exactly BUSY_TMO cycles after `dds_start`; state IDLE; no `seq_done`.
- `abort` in WAIT_DONE → `dds_rst_n` low 1 cycle, `seq_busy` 0 next cycle; a new `run` restarts from profile 0.
- `cfg_we` during GAP → `cfg_err` pulse; readback after IDLE shows the old profile values.

Source files
------------

// File: rtl/lfm_pkg.sv
// Shared definitions for the LFM chirp sequencer.
//   - FREQ_W / LEN_W / GAP_W : field widths of one chirp profile
//   - profile_t              : one table entry {f_start, f_stop, chirp_len, gap}
//   - PROF_W                 : flattened width of profile_t (used on ports)
//   - state_t                : sequencer FSM encoding
package lfm_pkg;

    localparam int FREQ_W = 32;
    localparam int LEN_W  = 64;
    localparam int GAP_W  = 32;

    typedef struct packed {
        logic [FREQ_W-1:0] f_start;
        logic [FREQ_W-1:0] f_stop;
        logic [LEN_W-1:0]  chirp_len;
        logic [GAP_W-1:0]  gap;
    } profile_t;

    localparam int PROF_W = $bits(profile_t);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_LOAD      = 3'd1,
        ST_START     = 3'd2,
        ST_WAIT_BUSY = 3'd3,
        ST_WAIT_DONE = 3'd4,
        ST_GAP       = 3'd5,
        ST_NEXT      = 3'd6
    } state_t;

endpackage

// File: rtl/lfm_profile_ram.sv
// Chirp profile table: one write port, one asynchronous read port.
// Ports:
//   clk, rst  : clock, synchronous active-high reset (clears every entry)
//   i_we      : write i_wdata into entry i_waddr
//   i_waddr   : write index
//   i_wdata   : flattened profile_t to write
//   i_raddr   : read index
//   o_rdata   : flattened profile_t at i_raddr (combinational read)
module lfm_profile_ram
    import lfm_pkg::*;
#(
    parameter int PROF_BITS = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_we,
    input  logic [PROF_BITS-1:0] i_waddr,
    input  logic [PROF_W-1:0]    i_wdata,
    input  logic [PROF_BITS-1:0] i_raddr,
    output logic [PROF_W-1:0]    o_rdata
);

    localparam int DEPTH = 1 << PROF_BITS;

    logic [PROF_W-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/lfm_chirp_sequencer.sv
// Profile-table sequencer in front of a dds_lfm core. Plays profiles
// 0..seq_last back-to-back for `loops` passes (0 = forever), one chirp per
// profile, with a per-profile idle gap after each chirp.
// Ports:
//   clk, rst                : clock, synchronous active-high reset
//   cfg_we/addr/f_start/f_stop/chirp_len/gap : profile table write (IDLE only)
//   cfg_err                 : one-cycle pulse, write rejected outside IDLE
//   seq_last, loops, run, abort : playback control
//   dds_rst_n, dds_start, dds_f_start, dds_f_stop, dds_chirp_len, dds_f_clk :
//                             drive to dds_lfm
//   dds_busy, dds_done      : status from dds_lfm
//   seq_busy, seq_done, cur_prof, pass_cnt, err : sequencer status
//   dbg_state               : current FSM state (state_t encoding)
//
// Handshake with dds_lfm: dds_start is a single-cycle request carrying the
// dds_* data registers, which stay stable until the next LOAD. The core
// acknowledges by raising dds_busy within BUSY_TMO cycles; completion is
// dds_done or the falling edge of dds_busy, whichever is seen first.
module lfm_chirp_sequencer
    import lfm_pkg::*;
#(
    parameter int          PROF_BITS = 2,
    parameter logic [31:0] F_CLK     = 32'd100_000_000,
    parameter int          BUSY_TMO  = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cfg_we,
    input  logic [PROF_BITS-1:0] cfg_addr,
    input  logic [31:0]          cfg_f_start,
    input  logic [31:0]          cfg_f_stop,
    input  logic [63:0]          cfg_chirp_len,
    input  logic [31:0]          cfg_gap,
    output logic                 cfg_err,
    input  logic [PROF_BITS-1:0] seq_last,
    input  logic [15:0]          loops,
    input  logic                 run,
    input  logic                 abort,
    output logic                 dds_rst_n,
    output logic                 dds_start,
    output logic [31:0]          dds_f_start,
    output logic [31:0]          dds_f_stop,
    output logic [63:0]          dds_chirp_len,
    output logic [31:0]          dds_f_clk,
    input  logic                 dds_busy,
    input  logic                 dds_done,
    output logic                 seq_busy,
    output logic                 seq_done,
    output logic [PROF_BITS-1:0] cur_prof,
    output logic [15:0]          pass_cnt,
    output logic                 err,
    output logic [2:0]           dbg_state
);

    localparam int TMO_W = $clog2(BUSY_TMO + 1);

    state_t               r_state;
    logic                 r_cfg_err;
    logic                 r_dds_rst_n;
    logic                 r_dds_start;
    logic [FREQ_W-1:0]    r_dds_f_start;
    logic [FREQ_W-1:0]    r_dds_f_stop;
    logic [LEN_W-1:0]     r_dds_chirp_len;
    logic [GAP_W-1:0]     r_gap_cnt;
    logic [TMO_W-1:0]     r_tmo_cnt;
    logic                 r_busy_q;
    logic                 r_seq_busy;
    logic                 r_seq_done;
    logic [PROF_BITS-1:0] r_cur_prof;
    logic [15:0]          r_pass_cnt;
    logic                 r_err;

    profile_t             w_wr_prof;
    logic [PROF_W-1:0]    w_rd_flat;
    profile_t             w_prof;
    logic                 w_cfg_wr;
    logic                 w_busy_fall;
    logic [15:0]          w_pass_nxt;

    assign w_wr_prof   = '{f_start: cfg_f_start, f_stop: cfg_f_stop,
                           chirp_len: cfg_chirp_len, gap: cfg_gap};
    assign w_prof      = profile_t'(w_rd_flat);
    assign w_cfg_wr    = cfg_we && (r_state == ST_IDLE);
    assign w_busy_fall = r_busy_q && !dds_busy;
    assign w_pass_nxt  = r_pass_cnt + 16'd1;

    lfm_profile_ram #(
        .PROF_BITS (PROF_BITS)
    ) u_ram (
        .clk     (clk),
        .rst     (rst),
        .i_we    (w_cfg_wr),
        .i_waddr (cfg_addr),
        .i_wdata (w_wr_prof),
        .i_raddr (r_cur_prof),
        .o_rdata (w_rd_flat)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state         <= ST_IDLE;
            r_cfg_err       <= 1'b0;
            r_dds_rst_n     <= 1'b0;
            r_dds_start     <= 1'b0;
            r_dds_f_start   <= '0;
            r_dds_f_stop    <= '0;
            r_dds_chirp_len <= '0;
            r_gap_cnt       <= '0;
            r_tmo_cnt       <= '0;
            r_busy_q        <= 1'b0;
            r_seq_busy      <= 1'b0;
            r_seq_done      <= 1'b0;
            r_cur_prof      <= '0;
            r_pass_cnt      <= '0;
            r_err           <= 1'b0;
        end else begin
            // Single-cycle pulses default low; dds_rst_n defaults released.
            r_dds_start <= 1'b0;
            r_seq_done  <= 1'b0;
            r_dds_rst_n <= 1'b1;
            r_busy_q    <= dds_busy;
            r_cfg_err   <= cfg_we && (r_state != ST_IDLE);

            if (abort && (r_state != ST_IDLE)) begin
                // Abort wins over every transition; the DDS core is reset
                // for one cycle so it drops whatever chirp is in flight.
                r_dds_rst_n <= 1'b0;
                r_seq_busy  <= 1'b0;
                r_state     <= ST_IDLE;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (run) begin
                            r_cur_prof <= '0;
                            r_pass_cnt <= '0;
                            r_err      <= 1'b0;
                            r_seq_busy <= 1'b1;
                            r_state    <= ST_LOAD;
                        end
                    end
                    ST_LOAD: begin
                        r_dds_f_start   <= w_prof.f_start;
                        r_dds_f_stop    <= w_prof.f_stop;
                        r_dds_chirp_len <= w_prof.chirp_len;
                        r_gap_cnt       <= w_prof.gap;
                        r_state         <= ST_START;
                    end
                    ST_START: begin
                        r_dds_start <= 1'b1;
                        r_tmo_cnt   <= '0;
                        r_state     <= ST_WAIT_BUSY;
                    end
                    ST_WAIT_BUSY: begin
                        // Counter holds k-1 on the k-th edge after dds_start,
                        // so err rises exactly BUSY_TMO cycles after the pulse.
                        if (dds_busy) begin
                            r_state <= ST_WAIT_DONE;
                        end else if (r_tmo_cnt == TMO_W'(BUSY_TMO - 1)) begin
                            r_err      <= 1'b1;
                            r_seq_busy <= 1'b0;
                            r_state    <= ST_IDLE;
                        end else begin
                            r_tmo_cnt <= r_tmo_cnt + 1'b1;
                        end
                    end
                    ST_WAIT_DONE: begin
                        // A zero gap bypasses GAP entirely to keep the
                        // done-to-next-start latency at 3 cycles.
                        if (dds_done || w_busy_fall) begin
                            r_state <= (r_gap_cnt == '0) ? ST_NEXT : ST_GAP;
                        end
                    end
                    ST_GAP: begin
                        // Entered with G loaded: G decrements plus one exit
                        // edge, i.e. G+1 cycles spent here.
                        if (r_gap_cnt == '0) begin
                            r_state <= ST_NEXT;
                        end else begin
                            r_gap_cnt <= r_gap_cnt - 1'b1;
                        end
                    end
                    ST_NEXT: begin
                        if (r_cur_prof != seq_last) begin
                            r_cur_prof <= r_cur_prof + 1'b1;
                            r_state    <= ST_LOAD;
                        end else begin
                            r_pass_cnt <= w_pass_nxt;
                            if ((loops != 16'd0) && (w_pass_nxt == loops)) begin
                                r_seq_done <= 1'b1;
                                r_seq_busy <= 1'b0;
                                r_state    <= ST_IDLE;
                            end else begin
                                r_cur_prof <= '0;
                                r_state    <= ST_LOAD;
                            end
                        end
                    end
                    default: begin
                        r_seq_busy <= 1'b0;
                        r_state    <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign cfg_err       = r_cfg_err;
    assign dds_rst_n     = r_dds_rst_n;
    assign dds_start     = r_dds_start;
    assign dds_f_start   = r_dds_f_start;
    assign dds_f_stop    = r_dds_f_stop;
    assign dds_chirp_len = r_dds_chirp_len;
    assign dds_f_clk     = F_CLK;
    assign seq_busy      = r_seq_busy;
    assign seq_done      = r_seq_done;
    assign cur_prof      = r_cur_prof;
    assign pass_cnt      = r_pass_cnt;
    assign err           = r_err;
    assign dbg_state     = r_state;

endmodule
